// File: rtl/com_test_port_if.sv
// rtl/com_test_port_if.sv - command/handshake bus between master SM and com_test_port
interface com_test_port_if #(
  parameter int NLED  = 4,
  parameter int DW    = 16,
  parameter int CNT_W = 8
);
  logic [15:0]      SysState;
  logic             Enable;
  logic [DW-1:0]    Arg;
  logic             Done;
  logic [NLED-1:0]  TestLED;
  logic [DW-1:0]    DataOut;
  logic [CNT_W-1:0] CmdCount;

  modport master (
    output SysState, Enable, Arg,
    input  Done, TestLED, DataOut, CmdCount
  );

  modport slave (
    input  SysState, Enable, Arg,
    output Done, TestLED, DataOut, CmdCount
  );
endinterface

// File: rtl/com_test_port.sv
// rtl/com_test_port.sv - test/diagnostic sub-SM: LED toggle, timed blink (COMTEST_BLINK_EN), echo, clear
module com_test_port #(
  parameter int          NLED       = 4,
  parameter int          DW         = 16,
  parameter int          BLINK_DIV  = 25000000,
  parameter int          CNT_W      = 8,
  parameter logic [15:0] CMD_TOGGLE = 16'h0001,
  parameter logic [15:0] CMD_BLINK  = 16'h0002,
  parameter logic [15:0] CMD_ECHO   = 16'h0003,
  parameter logic [15:0] CMD_CLEAR  = 16'h0004
) (
  input  logic           Clk,
  input  logic           Rst,
  com_test_port_if.slave bus
);

`ifdef COMTEST_BLINK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DONE, ST_BLINK} state_t;
  localparam int DIV_W = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BLINK_DIV - 1);
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [NLED-1:0]  led, led_nxt;
  logic [DW-1:0]    data, data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done, done_nxt;
  logic [NLED-1:0]  mask;

`ifdef COMTEST_BLINK_EN
  logic [DIV_W-1:0] div, div_nxt;
  logic [8:0]       tog, tog_nxt;
  logic [NLED-1:0]  saved, saved_nxt;
  logic [NLED-1:0]  bmask, bmask_nxt;
  logic [7:0]       nblink;

  assign nblink = (bus.Arg[15:8] == 8'd0) ? 8'd1 : bus.Arg[15:8];
`endif

  // A zero mask selects every LED.
  assign mask = (bus.Arg[NLED-1:0] == '0) ? '1 : bus.Arg[NLED-1:0];

  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    data_nxt  = data;
    cnt_nxt   = cnt;
    done_nxt  = done;
`ifdef COMTEST_BLINK_EN
    div_nxt   = div;
    tog_nxt   = tog;
    saved_nxt = saved;
    bmask_nxt = bmask;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.Enable && !done) begin
          if (bus.SysState == CMD_TOGGLE) begin
            led_nxt   = led ^ mask;
            cnt_nxt   = cnt + CNT_W'(1);
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else if (bus.SysState == CMD_ECHO) begin
            data_nxt  = bus.Arg;
            cnt_nxt   = cnt + CNT_W'(1);
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else if (bus.SysState == CMD_CLEAR) begin
            led_nxt   = '1;
            data_nxt  = '0;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
`ifdef COMTEST_BLINK_EN
          else if (bus.SysState == CMD_BLINK) begin
            saved_nxt = led;
            bmask_nxt = mask;
            tog_nxt   = {nblink, 1'b0};
            div_nxt   = DIV_LOAD;
            state_nxt = ST_BLINK;
          end
`endif
        end
      end
`ifdef COMTEST_BLINK_EN
      ST_BLINK: begin
        // Abort wins over a coinciding toggle so the LEDs always come back intact.
        if (!bus.Enable) begin
          led_nxt   = saved;
          state_nxt = ST_IDLE;
        end else if (div == '0) begin
          led_nxt = led ^ bmask;
          div_nxt = DIV_LOAD;
          tog_nxt = tog - 9'd1;
          if (tog == 9'd1) begin
            cnt_nxt   = cnt + CNT_W'(1);
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
        end else begin
          div_nxt = div - DIV_W'(1);
        end
      end
`endif
      ST_DONE: begin
        if (!bus.Enable) begin
          done_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
      led   <= '1;
      data  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef COMTEST_BLINK_EN
      div   <= '0;
      tog   <= '0;
      saved <= '1;
      bmask <= '0;
`endif
    end else begin
      state <= state_nxt;
      led   <= led_nxt;
      data  <= data_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
`ifdef COMTEST_BLINK_EN
      div   <= div_nxt;
      tog   <= tog_nxt;
      saved <= saved_nxt;
      bmask <= bmask_nxt;
`endif
    end
  end

  assign bus.Done     = done;
  assign bus.TestLED  = led;
  assign bus.DataOut  = data;
  assign bus.CmdCount = cnt;

endmodule

// File: tb/tb_com_test_port.sv
// tb/tb_com_test_port.sv - directed and randomized checks of com_test_port against a command-level model
module tb_com_test_port;
  logic Clk = 1'b0;
  logic Rst = 1'b0;

  always #5 Clk = ~Clk;

  com_test_port_if #(.NLED(4), .DW(16), .CNT_W(8)) bus ();

  com_test_port #(
    .NLED(4), .DW(16), .BLINK_DIV(4), .CNT_W(8)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_led;
  logic [15:0] m_data;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_led"},  bus.TestLED,  m_led);
    check({tag, "_data"}, bus.DataOut,  m_data);
    check({tag, "_cnt"},  bus.CmdCount, m_cnt);
  endtask

  task automatic model_reset();
    m_led  = 4'hF;
    m_data = 16'h0;
    m_cnt  = 8'h0;
  endtask

  // One full handshake: Enable up for one acceptance edge, then released.
  task automatic hs(input logic [15:0] cmd, input logic [15:0] arg, input string tag);
    logic [3:0] mask;
    bit known;
    @(negedge Clk);
    bus.SysState = cmd; bus.Arg = arg; bus.Enable = 1'b1;
    @(negedge Clk);
    mask  = (arg[3:0] == 4'h0) ? 4'hF : arg[3:0];
    known = 1'b1;
    case (cmd)
      16'h0001: begin m_led = m_led ^ mask; m_cnt = m_cnt + 8'd1; end
      16'h0003: begin m_data = arg; m_cnt = m_cnt + 8'd1; end
      16'h0004: begin m_led = 4'hF; m_data = 16'h0; m_cnt = 8'h0; end
      default:  known = 1'b0;
    endcase
    check({tag, "_done"}, bus.Done, known);
    check_outputs(tag);
    bus.Enable = 1'b0;
    if (known) begin
      @(negedge Clk);
      check({tag, "_done_fall"}, bus.Done, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] r_cmd;
    logic [15:0] r_arg;
    bus.SysState = 16'h0; bus.Arg = 16'h0; bus.Enable = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("reset_done", bus.Done, 1'b0);
    check_outputs("reset");
    Rst = 1'b1;

    // Toggle with sustained Enable: exactly one toggle per handshake.
    @(negedge Clk);
    bus.SysState = 16'h0001; bus.Arg = 16'h0; bus.Enable = 1'b1;
    @(negedge Clk);
    check("tog_led_1cyc", bus.TestLED, 4'h0);
    check("tog_done_1cyc", bus.Done, 1'b1);
    repeat (9) @(negedge Clk);
    m_led = 4'h0; m_cnt = 8'd1;
    check("tog_hold_done", bus.Done, 1'b1);
    check_outputs("tog_hold");
    bus.Enable = 1'b0;
    @(negedge Clk);
    check("tog_done_fall", bus.Done, 1'b0);

    hs(16'h0003, 16'hA5C3, "echo");

`ifdef COMTEST_BLINK_EN
    // Blink, N=2, LED0: toggles at +4,+8,+12,+16, Done at +16.
    @(negedge Clk);
    bus.SysState = 16'h0002; bus.Arg = 16'h0201; bus.Enable = 1'b1;
    @(negedge Clk);
    check("blink_led_0", bus.TestLED, m_led);
    for (int j = 1; j <= 16; j++) begin
      @(negedge Clk);
      bus.SysState = 16'h0001;
      check("blink_led", bus.TestLED, ((j / 4) % 2 == 1) ? (m_led ^ 4'h1) : m_led);
      check("blink_done", bus.Done, (j == 16));
    end
    m_cnt = m_cnt + 8'd1;
    check_outputs("blink_end");
    bus.Enable = 1'b0;
    @(negedge Clk);
    check("blink_done_fall", bus.Done, 1'b0);

    // Same blink aborted when Enable drops at +6.
    @(negedge Clk);
    bus.SysState = 16'h0002; bus.Arg = 16'h0201; bus.Enable = 1'b1;
    @(negedge Clk);
    for (int j = 1; j <= 5; j++) begin
      @(negedge Clk);
      if (j >= 4) check("abort_led_mid", bus.TestLED, m_led ^ 4'h1);
    end
    bus.Enable = 1'b0;
    @(negedge Clk);
    check("abort_done", bus.Done, 1'b0);
    check_outputs("abort");
    repeat (5) @(negedge Clk);
    check("abort_done_late", bus.Done, 1'b0);
    hs(16'h0001, 16'h0002, "after_abort");
`else
    // Without the blink feature the blink word is an unknown command.
    @(negedge Clk);
    bus.SysState = 16'h0002; bus.Arg = 16'h0201; bus.Enable = 1'b1;
    repeat (5) @(negedge Clk);
    check("noblink_done", bus.Done, 1'b0);
    check_outputs("noblink");
    bus.Enable = 1'b0;
`endif

    // Randomized command mix against the model.
    for (int i = 0; i < 40; i++) begin
      r_arg = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r_cmd = 16'h0001;
        1: r_cmd = 16'h0003;
        2: r_cmd = ($urandom_range(0, 3) == 0) ? 16'h0004 : 16'h0001;
        default: r_cmd = 16'($urandom_range(5, 65535));
      endcase
      hs(r_cmd, r_arg, "rnd");
    end

    // Counter wrap, then clear.
    hs(16'h0004, 16'h0, "pre_wrap_clear");
    for (int i = 0; i < 255; i++) hs(16'h0001, 16'($urandom), "wrap_fill");
    check("wrap_ff", bus.CmdCount, 8'hFF);
    hs(16'h0001, 16'h0001, "wrap");
    check("wrap_zero", bus.CmdCount, 8'h00);
    hs(16'h0003, 16'h1234, "pre_clear_echo");
    hs(16'h0004, 16'h0, "clear");

    // Unknown command held: no Done.
    @(negedge Clk);
    bus.SysState = 16'h0005; bus.Arg = 16'h00FF; bus.Enable = 1'b1;
    repeat (5) @(negedge Clk);
    check("unk_done", bus.Done, 1'b0);
    check_outputs("unk");
    bus.Enable = 1'b0;

    hs(16'h0001, 16'h0003, "pre_rst_tog");
    hs(16'h0003, 16'hBEEF, "pre_rst_echo");
`ifdef COMTEST_BLINK_EN
    @(negedge Clk);
    bus.SysState = 16'h0002; bus.Arg = 16'h0304; bus.Enable = 1'b1;
    repeat (6) @(negedge Clk);
    check("rst_mid_led", bus.TestLED, m_led ^ 4'h4);
`else
    @(negedge Clk);
    bus.SysState = 16'h0001; bus.Arg = 16'h0004; bus.Enable = 1'b1;
    @(negedge Clk);
    check("rst_mid_done", bus.Done, 1'b1);
`endif
    #2 Rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_done", bus.Done, 1'b0);
    check_outputs("rst_async");
    @(negedge Clk);
    bus.Enable = 1'b0;
    Rst = 1'b1;
    check_outputs("rst_after");
    hs(16'h0001, 16'h0008, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/com_test_port.md
# com_test_port

Parametrised command-driven test/diagnostic sub state machine for the ECT controller. It sits beside the other sub-SMs on the system state bus and responds only to its own command words. Supported commands: LED toggle, timed LED blink, data echo and clear. It uses the same Enable/Done handshake as every sub-SM and adds an LED mask, a command argument, an echo register and a completed-command counter.

## Interface
Parameters:
- NLED, 4: number of test LEDs, 1..8
- DW, 16: argument/echo width, must be ≥16
- BLINK_DIV, 25000000: clock cycles per blink half-period, ≥2
- CNT_W, 8: width of completed-command counter
- CMD_TOGGLE, 16'h0001: toggle command word
- CMD_BLINK, 16'h0002: blink command word
- CMD_ECHO, 16'h0003: echo command word
- CMD_CLEAR, 16'h0004: clear command word

Ports:
- Clk input 1: system clock; the only clock
- Rst input 1: reset, asynchronous, active-low
- SysState input 16: system state / command word
- Enable input 1: handshake request from master SM
- Arg input DW: command argument
- Done output 1: command complete, registered
- TestLED output NLED: test LEDs, active-low (1 = off)
- DataOut output DW: echo register
- CmdCount output CNT_W: completed-command counter

## Operation
- Reset: TestLED all 1, Done 0, DataOut 0, CmdCount 0, state IDLE, blink counters 0.
- mask = Arg[NLED-1:0]. If mask is 0, all LEDs are used.
- States are IDLE, BLINK, DONE.
- IDLE with Enable=1 and Done=0, decoded on a full 16-bit SysState compare:
  - CMD_TOGGLE: TestLED ^= mask; go DONE.
  - CMD_ECHO: DataOut <= Arg; go DONE.
  - CMD_CLEAR: TestLED <= all 1, DataOut <= 0, CmdCount <= 0; go DONE.
  - CMD_BLINK: save TestLED, load toggles = 2×N where N = Arg[15:8] and N=0 is treated as 1; load div counter; go BLINK.
  - Any other SysState: no action; stay IDLE; Done stays 0.
- BLINK:
  - Div counter counts BLINK_DIV cycles.
  - On terminal count: TestLED ^= mask, decrement toggles, reload div counter.
  - After the last toggle, TestLED equals the saved value; go DONE.
  - Enable=0 in BLINK aborts the command: TestLED restored to the saved value, Done stays 0, CmdCount unchanged, go IDLE.
- DONE:
  - Done=1.
  - Sustained Enable=1 holds DONE with no retrigger. An LED toggles exactly once per handshake.
  - Enable=0 sampled: Done <= 0, go IDLE.
- CmdCount increments by 1 on entry to DONE for TOGGLE, ECHO and BLINK. It wraps modulo 2^CNT_W (all-ones +1 → 0). CLEAR sets it to 0 and does not count itself.
- SysState changes while in BLINK or DONE are ignored. The command is latched at acceptance.

## Timing
- TOGGLE/ECHO/CLEAR: Enable=1 sampled at edge k → outputs updated and Done=1 at edge k (1-cycle latency).
- BLINK: accepted at edge k. Toggle i (1..2N) occurs at edge k + i×BLINK_DIV. Done=1 at edge k + 2N×BLINK_DIV.
- Done falls at the first edge where Enable=0 is sampled in DONE.
- Earliest next acceptance is the following edge, provided Enable=1 again. Minimum handshake period is 2 cycles plus execution time.
- Rst low at any time forces reset values asynchronously. That includes mid-blink, where LEDs go to all 1 rather than the saved value.

## Configuration
- COMTEST_BLINK_EN defined:
  - CMD_BLINK is implemented as above.
  - The BLINK state, divider (ceil(log2 BLINK_DIV) bits), toggle counter and saved-LED register are present.
- COMTEST_BLINK_EN undefined:
  - The BLINK state and its counters are not built.
  - CMD_BLINK is treated as an unknown command: no response, Done stays 0.
  - All other behaviour is identical.

## Test plan
Scenarios use BLINK_DIV=4 where timing is involved.
- Reset then SysState=16'h0001, Arg=0, Enable=1 for 10 cycles → TestLED=4'b0000 after 1 cycle, Done=1, LEDs toggle only once, CmdCount=1. Enable=0 → Done=0 next cycle.
- SysState=16'h0003, Arg=16'hA5C3, Enable pulse → DataOut=16'hA5C3, Done=1 at the acceptance edge, CmdCount increments.
- BLINK_DIV=4, SysState=16'h0002, Arg=16'h0201 → LED0 toggles at +4, +8, +12 and +16 cycles. Done=1 at +16. TestLED back to 4'b1111.
- Same blink, Enable dropped at +6 → TestLED restored to 4'b1111, Done never asserts, CmdCount unchanged, state IDLE.
- CmdCount preloaded to 8'hFF by 255 toggles, then one more toggle → CmdCount=0. Then CMD_CLEAR → CmdCount=0, TestLED=4'b1111, DataOut=0.
- SysState=16'h0005 with Enable=1, plus a mid-blink Rst pulse → the unknown command gives no Done. After Rst: all outputs at reset values, state IDLE. Build without COMTEST_BLINK_EN: CMD_BLINK gives no Done.
